// File: rtl/return_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
package return_stack_pkg;

  localparam int RS_AW    = 8;
  localparam int RS_DEPTH = 8;
  localparam logic [RS_AW-1:0] RS_RESET_ADDR = 8'h00;

  // One operation is resolved per cycle; flush outranks push/pop.
  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_FLUSH   = 3'd1,
    RS_PUSH    = 3'd2,
    RS_POP     = 3'd3,
    RS_PUSHPOP = 3'd4
  } rs_op_e;

  function automatic rs_op_e rs_decode(input logic flush, input logic push, input logic pop);
    if (flush)             return RS_FLUSH;
    else if (push && pop)  return RS_PUSHPOP;
    else if (push)         return RS_PUSH;
    else if (pop)          return RS_POP;
    else                   return RS_IDLE;
  endfunction

endpackage

// File: rtl/rs_ptr.sv
// Saturating up/down stack pointer; count doubles as the number of valid entries.
module rs_ptr #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next pointer: clear wins, opposing inc/dec cancel, both ends saturate.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && (count_q != CW'(DEPTH))) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer register with asynchronous reset to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/return_stack.sv
// Return-address stack: CALL pushes PC+1, RET pops; top is visible combinationally.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int AW    = RS_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [AW-1:0]              top_addr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage is intentionally not reset; an empty stack masks it.
  logic [AW-1:0] mem [DEPTH];

  rs_op_e        op;
  logic          ptr_inc;
  logic          ptr_dec;
  logic          ptr_clr;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          ovf_set;
  logic          unf_set;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  rs_ptr #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ptr_inc),
    .dec   (ptr_dec),
    .clr   (ptr_clr),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign op     = rs_decode(flush, push, pop);
  assign rd_idx = IW'(count - CW'(1));

  // Resolve the operation into pointer moves, a write slot and error events.
  always_comb begin
    ptr_inc = 1'b0;
    ptr_dec = 1'b0;
    ptr_clr = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = IW'(count);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      RS_FLUSH: ptr_clr = 1'b1;
      RS_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = IW'(count);
          ptr_inc = 1'b1;
        end
      end
      RS_POP: begin
        if (empty) unf_set = 1'b1;
        else       ptr_dec = 1'b1;
      end
      RS_PUSHPOP: begin
        // Replacing the top never grows the stack, so it is legal when full.
        // From empty the pop underflows and the push still lands in slot 0.
        wr_en = 1'b1;
        if (empty) begin
          unf_set = 1'b1;
          wr_idx  = '0;
          ptr_inc = 1'b1;
        end else begin
          wr_idx  = rd_idx;
        end
      end
      default: ;
    endcase
  end

  // Entry write port; only accepted pushes reach the array.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end

  // Sticky flags: a fresh error beats a simultaneous clear.
  always_comb begin
    overflow_d  = ovf_set | (overflow_q  & ~clr_err);
    underflow_d = unf_set | (underflow_q & ~clr_err);
  end

  // Error flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign top_addr  = empty ? AW'(RS_RESET_ADDR) : mem[rd_idx];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the 8-bit pipelined core. The fetch/decode stage pushes the already-incremented PC (the call's return address) on CALL and pops it on RET. The stack presents its current top combinationally from registered state, so RET can redirect fetch in the same cycle it pops. Overflow and underflow are reported as sticky error flags and never corrupt stored entries.

## Interface
Parameters:
- DEPTH, 8: number of 8-bit entries; power of two, 2..64.
- AW, 8: address width; fixed at 8 for this core.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  store push_addr as the new top.
- push_addr  in  AW  return address to store (PC+1 from fetch).
- pop  in  1  discard the current top.
- flush  in  1  synchronous clear of the stack pointer (pipeline flush / context reset).
- clr_err  in  1  synchronous clear of the sticky error flags.
- top_addr  out  AW  current top entry; 8'h00 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- overflow  out  1  sticky: a push was dropped because the stack was full.
- underflow  out  1  sticky: a pop was issued while the stack was empty.

## Operation
- State: entry array mem[0..DEPTH-1], which is not reset; pointer sp = count (0..DEPTH); sticky overflow and underflow flags.
- top_addr = mem[sp-1] when sp != 0, else 8'h00. Reads are combinational from registers; there is no read-during-write bypass.
- Per-cycle priority: flush, then push/pop.
  - flush: sp <- 0. push and pop are ignored that cycle. Flags are unaffected.
  - push only, not full: mem[sp] <- push_addr; sp <- sp+1.
  - push only, full: entry dropped; sp and mem unchanged; overflow <- 1.
  - pop only, not empty: sp <- sp-1.
  - pop only, empty: sp stays 0; underflow <- 1.
  - push and pop, not empty: replace the top. mem[sp-1] <- push_addr; sp unchanged. This case is legal when full, so overflow is not set.
  - push and pop, empty: underflow <- 1, then the push proceeds. mem[0] <- push_addr; sp <- 1.
- Error flags: an error set in the same cycle as clr_err wins. Flags are set with clr_err=1 only when a new error occurs in that cycle.
- Stored entries are only written by push. A dropped push or a flush never alters mem.

## Timing
- Reset values (asynchronous): sp=0, empty=1, full=0, count=0, top_addr=8'h00, overflow=0, underflow=0.
- Latency: an operation sampled at edge N is visible on top_addr/count/empty/full after edge N. There are zero wait states, and one operation is accepted every cycle.
- During a cycle with pop=1, top_addr shows the entry being popped. This is the RET target.
- If reset asserts mid-operation, the in-flight operation is abandoned and all outputs return to reset values immediately. mem contents are undefined but masked.
- Pointer arithmetic is unsigned and saturating at 0 and DEPTH. sp never wraps.

## Structure
- Shared package: address width constant (8), default stack depth, reset address constant 8'h00.
- One sub-module, rs_ptr: saturating up/down counter holding sp, with inputs inc, dec, clr and outputs count, empty, full.
- Entry array, write/replace logic, top mux and error flags stay in return_stack.

## Test plan
- Reset, then idle: empty=1, full=0, count=0, top_addr=8'h00, overflow=underflow=0.
- Push 8'h11, 8'h22, 8'h33 on successive cycles: after each edge, top_addr is 11, then 22, then 33, and count=3. Pop three times: top_addr 33→22→11 during the pops, then empty=1 and top_addr=00.
- Fill to DEPTH=8 with 8'h01..08, then push 8'hAA: full=1, overflow=1, top_addr=8'h08. Pop: top_addr=8'h07, and overflow stays 1 until clr_err.
- From empty, pop: underflow=1, count=0. Then push=pop=1 with 8'h5C: underflow stays 1, count=1, top_addr=8'h5C.
- With count=2 (top 8'h40), push=pop=1 with 8'h77: count=2, top_addr=8'h77. Pop: top_addr shows the previous second entry.
- With count=4: flush=1 and push=1 → count=0, top_addr=00. Assert rst asynchronously mid-cycle while push=1: outputs return to reset values before the next edge. clr_err and a new overflow in the same cycle → overflow=1.
